// File: rtl/grad_spi_ser.sv
// -----------------------------------------------------------------------------
// grad_spi_ser -- SPI serializer for the gradient DAC chain.
//
// A word from the gradient buffer is accepted together with a channel mask and
// a clock divider. The frame is then sent to every selected channel in
// ascending index order. Each frame is SETUP, SHIFT, HOLD and GAP, and each
// phase is measured in half-periods of SCLK (H = div + 1 clk cycles).
// A strobe that arrives while a transfer is in progress is dropped, and
// data_lost_o reports the drop.
//
// Ports
//   clk            : single clock; all logic is in this domain
//   rst            : asynchronous, active-high reset
//   data_i[31:0]   : word to send; bits [FRAME_BITS-1:0] go on the wire
//   valid_i[NCH]   : single-cycle strobe, bit k selects channel k
//   spi_clk_div_i  : SCLK half-period in clk cycles, minus 1
//   busy_o         : high while a transfer is in progress
//   data_lost_o    : one-cycle pulse when a strobe is dropped
//   sclk_o         : SPI clock, idle low
//   sdo_o          : SPI data, MSB first
//   csn_o[NCH]     : active-low chip selects, one per channel
// -----------------------------------------------------------------------------
module grad_spi_ser #(
  parameter int FRAME_BITS = 24,
  parameter int NCH        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     data_i,
  input  logic [NCH-1:0]  valid_i,
  input  logic [5:0]      spi_clk_div_i,
  output logic            busy_o,
  output logic            data_lost_o,
  output logic            sclk_o,
  output logic            sdo_o,
  output logic [NCH-1:0]  csn_o
);

  localparam int BIT_W = $clog2(2 * FRAME_BITS + 1);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [BIT_W-1:0] LAST_HALF = BIT_W'(2 * FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [CH_W-1:0] lowest_idx(input logic [NCH-1:0] m);
    lowest_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (m[k]) lowest_idx = CH_W'(k);
    end
  endfunction

  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  data_q, data_d;      // frame kept for later channels
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;    // MSB drives sdo_o
  logic [NCH-1:0]         pend_q, pend_d;      // channels still to be sent
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [5:0]             div_q, div_d;
  logic [5:0]             div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]       half_q, half_d;      // half-period index inside SHIFT
  logic                   lost_q, lost_d;

  logic                   tick;
  logic [CH_W-1:0]        first_ch;
  logic [CH_W-1:0]        next_ch;

  // Only the low FRAME_BITS of data_i go on the wire.
  generate
    if (FRAME_BITS < 32) begin : g_unused_data
      logic data_hi_unused;
      assign data_hi_unused = ^data_i[31:FRAME_BITS];
    end
  endgenerate

  assign tick     = (div_cnt_q == 6'd0);
  assign first_ch = lowest_idx(valid_i);
  assign next_ch  = lowest_idx(pend_q);

  // NOTE: every *_d gets its hold value first, so no path through this block
  // leaves a variable unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    shreg_d   = shreg_q;
    pend_d    = pend_q;
    ch_d      = ch_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    half_d    = half_q;
    lost_d    = (valid_i != '0) && (state_q != S_IDLE);

    // Reload at each half-period boundary so that H stays exact in every phase.
    if (state_q != S_IDLE) begin
      div_cnt_d = tick ? div_q : div_cnt_q - 6'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (valid_i != '0) begin
          data_d    = data_i[FRAME_BITS-1:0];
          shreg_d   = data_i[FRAME_BITS-1:0];
          div_d     = spi_clk_div_i;
          div_cnt_d = spi_clk_div_i;
          ch_d      = first_ch;
          pend_d    = valid_i & ~(NCH'(1) << first_ch);
          half_d    = '0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) begin
          half_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (half_q == LAST_HALF) begin
            state_d = S_HOLD;
          end else begin
            half_d = half_q + 1'b1;
            // Leaving a rising half: the falling half presents the next bit.
            // After FRAME_BITS shifts the register holds zero, so sdo_o is 0.
            if (!half_q[0]) shreg_d = shreg_q << 1;
          end
        end
      end
      S_HOLD: begin
        if (tick) state_d = S_GAP;
      end
      S_GAP: begin
        if (tick) begin
          if (pend_q != '0) begin
            ch_d    = next_ch;
            pend_d  = pend_q & ~(NCH'(1) << next_ch);
            shreg_d = data_q;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  // NOTE: every register is a flop here, so all of them are cleared on reset.
  // That also aborts a frame with no further SCLK edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      shreg_q   <= '0;
      pend_q    <= '0;
      ch_q      <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      half_q    <= '0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      shreg_q   <= shreg_d;
      pend_q    <= pend_d;
      ch_q      <= ch_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      half_q    <= half_d;
      lost_q    <= lost_d;
    end
  end

  // Outputs decode registered state only, so reset forces them at once.
  // Within SHIFT, even half indices are the SCLK-high halves.
  assign busy_o      = (state_q != S_IDLE);
  assign data_lost_o = lost_q;
  assign sclk_o      = (state_q == S_SHIFT) && !half_q[0];
  assign sdo_o       = ((state_q == S_SETUP) || (state_q == S_SHIFT)) ?
                       shreg_q[FRAME_BITS-1] : 1'b0;

  always_comb begin
    csn_o = '1;
    if ((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD)) begin
      csn_o[ch_q] = 1'b0;
    end
  end

endmodule
